// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell with a registered borrow.
// Start accepted in IDLE/DONE; result and done appear WIDTH cycles later; start ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             x, y, d_bit, bw_next;
  logic [WIDTH-1:0] acc_next;

  assign x        = a_sr_q[0];
  assign y        = b_sr_q[0];
  assign d_bit    = x ^ y ^ bw_q;
  assign bw_next  = (~x & y) | (~(x ^ y) & bw_q);
  assign acc_next = {d_bit, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        acc_d  = acc_next;
        bw_d   = bw_next;
        cnt_d  = cnt_q + CW'(1);
        // Result registers are only touched here, so partial sums never leak out.
        if (cnt_q == LAST) begin
          diff_d   = acc_next;
          borrow_d = bw_next;
          zero_d   = (acc_next == '0);
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): scoreboard of expected results, one task per scenario.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b, diff;
  logic       borrow_out, zero, ovf, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       ov;
  } exp_t;

  exp_t sb[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .diff(diff), .borrow_out(borrow_out), .zero(zero), .ovf(ovf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   sd;
    e.d  = 8'(x - y);
    e.bo = (x < y);
    e.z  = (e.d == 8'd0);
    sd   = int'($signed(x)) - int'($signed(y));
    e.ov = (sd > 127) || (sd < -128);
    return e;
  endfunction

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Returns at the negedge after done is seen (or after the bound expires).
  task automatic wait_done(input int pulse_at, output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (cyc < 40) begin
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({diff, borrow_out, zero, ovf, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {diff, borrow_out, zero, ovf, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int   cyc, bc;
    exp_t e;
    issue(8'h5A, 8'h23);
    wait_done(-1, cyc, bc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL basic_done_busy: got %b want 10", {done, busy}); end
    e = sb.pop_front();
    checks++;
    if (diff !== e.d) begin errors++; $display("FAIL basic_diff: got %h want %h", diff, e.d); end
    checks++;
    if (borrow_out !== e.bo) begin errors++; $display("FAIL basic_borrow: got %b want %b", borrow_out, e.bo); end
    checks++;
    if (zero !== e.z) begin errors++; $display("FAIL basic_zero: got %b want %b", zero, e.z); end
    checks++;
    if (ovf !== e.ov) begin errors++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ov); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_vectors();
    logic [7:0] va[6] = '{8'h10, 8'h00, 8'h80, 8'h7F, 8'h33, 8'hFF};
    logic [7:0] vb[6] = '{8'h20, 8'hFF, 8'h01, 8'hFF, 8'h33, 8'h7F};
    int   cyc, bc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i]);
      wait_done(-1, cyc, bc);
      e = sb.pop_front();
      checks++;
      if (cyc !== 8) begin errors++; $display("FAIL vec%0d_latency: got %0d want 8", i, cyc); end
      checks++;
      if ({diff, borrow_out, zero, ovf} !== e) begin
        errors++;
        $display("FAIL vec%0d_result: got d=%h bo=%b z=%b ov=%b want d=%h bo=%b z=%b ov=%b",
                 i, diff, borrow_out, zero, ovf, e.d, e.bo, e.z, e.ov);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int   cyc, bc;
    exp_t e;
    issue(8'h05, 8'h03);
    wait_done(3, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL ignore_latency: got %0d want 8", cyc); end
    checks++;
    if ({diff, borrow_out, zero, ovf} !== e) begin
      errors++;
      $display("FAIL ignore_result: got d=%h z=%b want d=%h z=%b", diff, zero, e.d, e.z);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ignore_no_queue: got %b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    int   cyc, bc;
    exp_t e1, e2;
    issue(8'h5A, 8'h23);
    wait_done(-1, cyc, bc);
    e1 = sb.pop_front();
    checks++;
    if ({diff, borrow_out, zero, ovf} !== e1) begin errors++; $display("FAIL b2b_first: got %h want %h", diff, e1.d); end
    issue(8'h09, 8'h04);
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got %b want 10", {busy, done}); end
    checks++;
    if ({diff, borrow_out, zero, ovf} !== e1) begin errors++; $display("FAIL b2b_hold: got %h want %h", diff, e1.d); end
    wait_done(-1, cyc, bc);
    e2 = sb.pop_front();
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", cyc); end
    checks++;
    if ({diff, borrow_out, zero, ovf} !== e2) begin errors++; $display("FAIL b2b_second: got %h want %h", diff, e2.d); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int   cyc, bc;
    logic seen_done;
    exp_t e;
    issue(8'hC3, 8'h12);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({diff, borrow_out, zero, ovf, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got %h want 0", {diff, borrow_out, zero, ovf, busy, done});
    end
    void'(sb.pop_front());
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_done |= done;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL midop_no_done: got %b want 0", seen_done); end
    rst = 1'b0;
    @(negedge clk);
    issue(8'hC3, 8'h12);
    wait_done(-1, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL midop_fresh_latency: got %0d want 8", cyc); end
    checks++;
    if ({diff, borrow_out, zero, ovf} !== e) begin errors++; $display("FAIL midop_fresh_result: got %h want %h", diff, e.d); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` LSB-first through a single full-subtractor cell with a registered borrow, one bit per clock. It is the inverse-operation companion of the team's ripple full-adder datapath and serves the ALU lab datapath where area matters more than latency. It provides a start/busy/done handshake and registered result flags: difference, borrow, zero and signed overflow.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state and outputs.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `diff`  out  WIDTH  registered result `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1  final borrow; 1 iff `a < b` unsigned.
- `zero`  out  1  1 iff `diff == 0`.
- `ovf`  out  1  two's-complement overflow of `a - b`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse when the result registers update.

## Operation
- States are IDLE, SHIFT and DONE. Reset drives the block to IDLE.
- **IDLE or DONE, `start`=1:** capture `a` and `b` into shift registers, latch `a[WIDTH-1]` and `b[WIDTH-1]`, clear the borrow FF, set count to 0, go to SHIFT.
- **DONE, `start`=0:** go to IDLE.
- **SHIFT, each cycle:** take `x = a_sr[0]`, `y = b_sr[0]`, `bw` = borrow FF.
  - `d = x ^ y ^ bw`
  - `bw_next = (~x & y) | (~(x ^ y) & bw)`
  - Shift `a_sr` and `b_sr` right by one.
  - Shift the internal diff register right, inserting `d` at the MSB.
  - Increment count.
- **SHIFT, `count == WIDTH-1`:** this edge also:
  - loads `diff` with the final shifted value and `borrow_out` with `bw_next`;
  - sets `zero = (final diff == 0)`;
  - sets `ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`;
  - goes to DONE.
- `start` in SHIFT is ignored; no queuing.
- Output registers (`diff`, `borrow_out`, `zero`, `ovf`) change only on the DONE-entry edge. They hold their values through IDLE and through the next operation until its DONE.
- `a` and `b` may change freely after the accepting edge.

## Timing
- **Reset value:** `diff`=0, `borrow_out`=0, `zero`=0, `ovf`=0, `busy`=0, `done`=0, state IDLE.
- **Latency:** `start` accepted at edge 0; shifts occur at edges 1..WIDTH. At edge WIDTH the results load and `done` goes high for exactly the cycle between edges WIDTH and WIDTH+1.
- **`busy`:** high from edge 0 to edge WIDTH, i.e. for WIDTH cycles.
- **`busy` and `done`:** never high together.
- **Back-to-back:** `start` during the DONE cycle is accepted. Throughput is one result per WIDTH+1 cycles. `done` still lasts exactly one cycle.
- **Reset mid-operation:**
  - immediate abort to IDLE;
  - all outputs return to reset values;
  - no `done`;
  - a partial result is never visible on outputs.
- **Wrap-around:** `diff` is modulo 2^WIDTH. Borrow out of the MSB appears only on `borrow_out`.

## Test plan
- WIDTH=8, a=0x5A, b=0x23 → at `done`: diff=0x37, borrow_out=0, zero=0, ovf=0. `done` is high exactly 8 cycles after the accepting edge, and `busy` was high for 8 cycles.
- a=0x10, b=0x20 → diff=0xF0, borrow_out=1, ovf=0. Also a=0x00, b=0xFF → diff=0x01, borrow_out=1.
- a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow_out=0. Also a=0x7F, b=0xFF → diff=0x80, ovf=1, borrow_out=1.
- a=0x33, b=0x33 → diff=0x00, zero=1. Then pulse `start` 3 cycles into a following op (a=0x05, b=0x03) → ignored, and the op completes with diff=0x02 and zero=0.
- **Back-to-back:** `start` held high through DONE with new operands a=0x09, b=0x04 → second `done` follows 8 cycles later with diff=0x05. Outputs hold the first result until then.
- **Reset mid-op:** assert `rst` asynchronously at shift 4 of 8 → all outputs 0 immediately, state IDLE, no `done`. A fresh op after release gives a correct result.
